// File: rtl/fp32_add_csr.sv
// fp32_add_csr: memory-mapped IEEE-754 single-precision adder slave on the UDM bus.
//   Registers (byte offsets from BASE_ADDR): +0x0 OPA (rw), +0x4 OPB (rw, a write
//   starts an add), +0x8 RES (ro), +0xC STATUS (ro: bit0 busy, bit1 done, sticky).
//   An add takes five cycles: UNPACK, ALIGN, ADD, NORM, ROUND.
// Ports:
//   clk_i, rst_i (synchronous, active-high)
//   bus_req_i, bus_we_i, bus_addr_i[31:0], bus_be_i[3:0], bus_wdata_i[31:0]
//   bus_ack_o   : combinational accept in the request cycle
//   bus_resp_o  : one-cycle read-data-valid pulse, registered
//   bus_rdata_o : read data, nonzero only while bus_resp_o is 1
// Build option: define FP32ADD_RES_STALL_EN to hold off RES reads until an
//   in-flight add has finished; otherwise RES reads are acked at once.
module fp32_add_csr #(
    parameter logic [31:0] BASE_ADDR = 32'h00000008
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_i,
    input  logic [3:0]  bus_be_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_o
);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;

    state_t state_q, state_d;
    logic [31:0] opa_q, opb_q, res_q, rdata_q;
    logic        done_q, resp_q;

    // Leading-zero count of a 27-bit mantissa path.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt   = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

    // Round to nearest even, then pack with underflow-to-+0 and overflow-to-Inf.
    function automatic logic [31:0] round_pack(input logic sign,
                                               input logic signed [9:0] e,
                                               input logic [26:0] m);
        logic               rup;
        logic [24:0]        mr;
        logic signed [9:0]  e2;
        logic [22:0]        frac;
        rup  = m[2] & (m[1] | m[0] | m[3]);
        mr   = {1'b0, m[26:3]} + {24'd0, rup};
        e2   = mr[24] ? e + 10'sd1 : e;
        frac = mr[24] ? mr[23:1] : mr[22:0];
        if (e2 <= 10'sd0)        return 32'h0000_0000;
        else if (e2 >= 10'sd255) return {sign, 8'hFF, 23'd0};
        else                     return {sign, e2[7:0], frac};
    endfunction

    // ---------------- bus decode ----------------
    logic [31:0] offset;
    logic        in_win, word_ok, sel_opa, sel_opb, sel_res, sel_sts;
    logic        busy, res_rd_ok, wr_ok, rd_ok, wr_full, start;

    assign offset  = bus_addr_i - BASE_ADDR;
    assign in_win  = bus_req_i && (offset < 32'd16);
    assign word_ok = (offset[1:0] == 2'b00);
    assign sel_opa = word_ok && (offset[3:2] == 2'd0);
    assign sel_opb = word_ok && (offset[3:2] == 2'd1);
    assign sel_res = word_ok && (offset[3:2] == 2'd2);
    assign sel_sts = word_ok && (offset[3:2] == 2'd3);
    assign busy    = (state_q != IDLE);

`ifdef FP32ADD_RES_STALL_EN
    assign res_rd_ok = !busy;
`else
    assign res_rd_ok = 1'b1;
`endif

    assign wr_ok     = in_win && bus_we_i && !busy && !rst_i;
    assign rd_ok     = in_win && !bus_we_i && !rst_i && (!sel_res || res_rd_ok);
    assign bus_ack_o = wr_ok || rd_ok;
    assign wr_full   = wr_ok && (bus_be_i == 4'hF);
    assign start     = wr_full && sel_opb;

    logic [31:0] rd_val;
    always_comb begin
        rd_val = 32'd0;
        if (sel_opa)      rd_val = opa_q;
        else if (sel_opb) rd_val = opb_q;
        else if (sel_res) rd_val = res_q;
        else if (sel_sts) rd_val = {30'd0, done_q, busy};
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = UNPACK;
            UNPACK:  state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- UNPACK (combinational view of the operands) ----------------
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [30:0] mag_a, mag_b;
    logic        a_nan, b_nan, a_inf, b_inf, swap, spec_c;
    logic [31:0] spec_val_c;
    always_comb begin
        ea    = opa_q[30:23];
        eb    = opb_q[30:23];
        a_nan = (&ea) && (|opa_q[22:0]);
        b_nan = (&eb) && (|opb_q[22:0]);
        a_inf = (&ea) && !(|opa_q[22:0]);
        b_inf = (&eb) && !(|opb_q[22:0]);
        // Denormals flush to zero: no hidden bit, zero magnitude.
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, opa_q[22:0]};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, opb_q[22:0]};
        mag_a = (ea == 8'd0) ? 31'd0 : opa_q[30:0];
        mag_b = (eb == 8'd0) ? 31'd0 : opb_q[30:0];
        swap  = (mag_b > mag_a);
        spec_c     = 1'b0;
        spec_val_c = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (opa_q[31] ^ opb_q[31]))) begin
            spec_c     = 1'b1;
            spec_val_c = 32'h7FC0_0000;
        end else if (a_inf) begin
            spec_c     = 1'b1;
            spec_val_c = opa_q;
        end else if (b_inf) begin
            spec_c     = 1'b1;
            spec_val_c = opb_q;
        end
    end

    // ALIGN: right-shift the smaller mantissa, folding shifted-out bits into sticky.
    logic                sgn_a_p0, sgn_b_p0, spec_p0;
    logic signed [9:0]   exp_p0;
    logic [23:0]         man_a_p0, man_b_p0;
    logic [7:0]          diff_p0;
    logic [31:0]         spec_val_p0;
    logic [26:0]         mb_ext, mb_shift, mb_align;
    always_comb begin
        mb_ext   = {man_b_p0, 3'b000};
        mb_shift = mb_ext >> diff_p0[4:0];
        if (diff_p0 >= 8'd27)
            mb_align = {26'd0, |man_b_p0};
        else
            mb_align = {mb_shift[26:1],
                        mb_shift[0] | (|(mb_ext & ~(27'h7FF_FFFF << diff_p0[4:0])))};
    end

    logic [26:0]       ma_p1, mb_p1;
    logic [27:0]       sum_p2;
    logic [26:0]       m_p3;
    logic signed [9:0] exp_p3;
    logic              zero_p3;
    logic [4:0]        lz;
    assign lz = lzc27(sum_p2[26:0]);

    // ---------------- datapath stage registers ----------------
    always_ff @(posedge clk_i) begin
        case (state_q)
            UNPACK: begin
                sgn_a_p0    <= swap ? opb_q[31] : opa_q[31];
                sgn_b_p0    <= swap ? opa_q[31] : opb_q[31];
                exp_p0      <= signed'({2'b00, swap ? eb : ea});
                man_a_p0    <= swap ? mb : ma;
                man_b_p0    <= swap ? ma : mb;
                diff_p0     <= swap ? (eb - ea) : (ea - eb);
                spec_p0     <= spec_c;
                spec_val_p0 <= spec_val_c;
            end
            ALIGN: begin
                ma_p1 <= {man_a_p0, 3'b000};
                mb_p1 <= mb_align;
            end
            ADD: begin
                sum_p2 <= (sgn_a_p0 == sgn_b_p0) ? ({1'b0, ma_p1} + {1'b0, mb_p1})
                                                 : ({1'b0, ma_p1} - {1'b0, mb_p1});
            end
            NORM: begin
                zero_p3 <= (sum_p2 == 28'd0);
                if (sum_p2[27]) begin
                    m_p3   <= {sum_p2[27:2], sum_p2[1] | sum_p2[0]};
                    exp_p3 <= exp_p0 + 10'sd1;
                end else begin
                    m_p3   <= sum_p2[26:0] << lz;
                    exp_p3 <= exp_p0 - signed'({5'd0, lz});
                end
            end
            default: ;
        endcase
    end

    // ---------------- control, CSRs and bus response ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            res_q   <= 32'd0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            resp_q  <= rd_ok;
            rdata_q <= rd_ok ? rd_val : 32'd0;
            if (wr_full && sel_opa) opa_q <= bus_wdata_i;
            if (start) begin
                opb_q  <= bus_wdata_i;
                done_q <= 1'b0;
            end
            if (state_q == ROUND) begin
                res_q  <= spec_p0 ? spec_val_p0
                        : zero_p3 ? 32'd0
                        : round_pack(sgn_a_p0, exp_p3, m_p3);
                done_q <= 1'b1;
            end
        end
    end

    assign bus_resp_o  = resp_q;
    assign bus_rdata_o = rdata_q;

endmodule

// File: tb/tb_fp32_add_csr.sv
module tb_fp32_add_csr;

    localparam logic [31:0] A_OPA = 32'h08;
    localparam logic [31:0] A_OPB = 32'h0C;
    localparam logic [31:0] A_RES = 32'h10;
    localparam logic [31:0] A_STS = 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_resp;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    fp32_add_csr dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_req_i   (bus_req),
        .bus_we_i    (bus_we),
        .bus_addr_i  (bus_addr),
        .bus_be_i    (bus_be),
        .bus_wdata_i (bus_wdata),
        .bus_ack_o   (bus_ack),
        .bus_resp_o  (bus_resp),
        .bus_rdata_o (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, output int waited);
        waited = 0;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data; bus_be = be;
        @(negedge clk);
        while (!bus_ack && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!bus_ack) check("write_ack_timeout", {31'd0, bus_ack}, 32'd1);
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output int waited);
        waited = 0;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_be = 4'hF;
        @(negedge clk);
        while (!bus_ack && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!bus_ack) check("read_ack_timeout", {31'd0, bus_ack}, 32'd1);
        @(posedge clk); #1;
        bus_req = 1'b0;
        @(negedge clk);
        check("read_resp", {31'd0, bus_resp}, 32'd1);
        data = bus_rdata;
        @(posedge clk); #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        logic [31:0] d;
        int          w;
        bus_read(addr, d, w);
        check(tag, d, expv);
    endtask

    task automatic start_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int w;
        bus_write(A_OPA, a, 4'hF, w);
        bus_write(A_OPB, b, 4'hF, w);
        exp_q.push_back(expv);
    endtask

    task automatic finish_add(input string tag);
        logic [31:0] d, e;
        int          w;
        repeat (10) @(posedge clk);
        #1;
        bus_read(A_RES, d, w);
        e = exp_q.pop_front();
        check(tag, d, e);
        last_res = e;
    endtask

    logic [31:0] tv_a[9] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                             32'hBECCCCCD, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
                             32'h7F800000};
    logic [31:0] tv_b[9] = '{32'h40200000, 32'h40200000, 32'hC0200000, 32'hC0200000,
                             32'h3E99999A, 32'hBF800000, 32'h33800000, 32'h7F7FFFFF,
                             32'hFF800000};
    logic [31:0] tv_r[9] = '{32'h40600000, 32'h3FC00000, 32'hBFC00000, 32'hC0600000,
                             32'hBDCCCCCC, 32'h00000000, 32'h3F800000, 32'h7F800000,
                             32'h7FC00000};

    initial begin
        logic [31:0] d;
        int          w;

        rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0;
        bus_addr = 32'd0; bus_wdata = 32'd0; bus_be = 4'h0;
        last_res = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ack", {31'd0, bus_ack}, 32'd0);
        check("rst_resp", {31'd0, bus_resp}, 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        @(posedge clk); #1;
        read_check("rst_status", A_STS, 32'd0);
        read_check("rst_res", A_RES, 32'd0);
        read_check("rst_opa", A_OPA, 32'd0);

        // Directed arithmetic vectors
        for (int i = 0; i < 9; i++) begin
            start_add(tv_a[i], tv_b[i], tv_r[i]);
            finish_add($sformatf("add_%0d", i));
            if (i == 0) read_check("status_done", A_STS, 32'h2);
        end

        // Denormal operand flushed to zero
        start_add(32'h00000001, 32'h3F800000, 32'h3F800000);
        finish_add("denorm_flush");

        // RES read right after an OPB write
        start_add(32'h40000000, 32'h40400000, 32'h40A00000);
        bus_read(A_RES, d, w);
`ifdef FP32ADD_RES_STALL_EN
        check("res_stall_wait", 32'(w), 32'd5);
        check("res_stall_data", d, exp_q.pop_front());
        last_res = 32'h40A00000;
`else
        check("res_nostall_wait", 32'(w), 32'd0);
        check("res_nostall_data", d, last_res);
        read_check("status_busy", A_STS, 32'h1);
        finish_add("res_after_poll");
`endif

        // Write while busy is held off until the FSM returns to IDLE
        start_add(32'h3F800000, 32'h3F800000, 32'h40000000);
        bus_write(A_OPA, 32'h40400000, 4'hF, w);
        check("busy_write_wait", 32'(w), 32'd5);
        finish_add("busy_write_sum");
        read_check("opa_after_busy", A_OPA, 32'h40400000);

        // Partial byte enables, hole address, out-of-window request
        bus_write(A_OPA, 32'h0, 4'h3, w);
        check("partial_be_wait", 32'(w), 32'd0);
        read_check("partial_be_ignored", A_OPA, 32'h40400000);
        read_check("hole_read", 32'h0000000A, 32'd0);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h100;
        @(negedge clk);
        check("out_of_window_ack", {31'd0, bus_ack}, 32'd0);
        @(posedge clk); #1 bus_req = 1'b0;

        // Reset in the middle of an add, with a read pending
        start_add(32'h3F800000, 32'h40200000, 32'h40600000);
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_OPA;
        @(posedge clk); #1;
        rst = 1'b0; bus_req = 1'b0;
        @(negedge clk);
        check("rst_mid_resp", {31'd0, bus_resp}, 32'd0);
        @(posedge clk); #1;
        read_check("rst_mid_res", A_RES, 32'd0);
        read_check("rst_mid_status", A_STS, 32'd0);
        read_check("rst_mid_opa", A_OPA, 32'd0);
        start_add(32'h40000000, 32'h40000000, 32'h40800000);
        finish_add("after_rst_add");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp32_add_csr.md
# fp32_add_csr

- Memory-mapped IEEE-754 single-precision adder slave on the UDM bus inside the NEXYS4_DDR top.
- Holds two operand registers and one result register. A write to operand B starts a fixed-latency multi-cycle add pipeline.
- The host reads the sum back through the same bus. The block is the direct downstream consumer of UDM bus transactions at addresses 0x08–0x14.

## Interface
- `BASE_ADDR`, default 32'h00000008: byte address of the OPA register. The other registers sit at fixed offsets from it.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `bus_req_i`  in  1  transaction request from UDM.
- `bus_we_i`  in  1  1 = write, 0 = read.
- `bus_addr_i`  in  32  byte address.
- `bus_be_i`  in  4  byte enables. Writes with `bus_be_i` != 4'hF are ignored but still acked.
- `bus_wdata_i`  in  32  write data.
- `bus_ack_o`  out  1  request accepted, combinational in the request cycle.
- `bus_resp_o`  out  1  read data valid, one-cycle pulse.
- `bus_rdata_o`  out  32  read data, valid only while `bus_resp_o` is 1.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - +0x0 OPA, read/write.
  - +0x4 OPB, read/write; a write starts an add.
  - +0x8 RES, read-only.
  - +0xC STATUS, read-only: bit0 = busy, bit1 = done (sticky; cleared by an OPB write).
- Any other address in the decoded 16-byte window: write is acked and dropped; read returns 0.
- FSM states and transitions:
  - IDLE → UNPACK on an accepted OPB write.
  - UNPACK → ALIGN → ADD → NORM → ROUND → IDLE, one cycle each.
- Work done in each state:
  - UNPACK: split sign, exponent and mantissa, inserting the hidden bit. Swap operands so |A| ≥ |B|.
  - ALIGN: barrel right-shift the smaller mantissa by the exponent difference, into a 27-bit path (24 + guard + round + sticky). Shift amounts ≥ 26 leave only sticky.
  - ADD: add the mantissas when signs are equal, otherwise subtract. Result is 28 bits.
  - NORM: on carry, right-shift by 1 and increment the exponent. Otherwise count leading zeros and left-shift, decrementing the exponent. A zero magnitude gives +0.
  - ROUND: round to nearest, ties to even. A mantissa carry-out increments the exponent. Write RES and set done.
- Special cases, resolved in UNPACK and forwarded to RES at ROUND:
  - Any NaN → 0x7FC00000.
  - +Inf + −Inf → 0x7FC00000.
  - Inf + finite → that Inf.
- Denormal inputs are flushed to ±0. Underflow results flush to +0.
- Exponent overflow after round → ±Inf (0x7F800000 | sign).
- Exact cancellation x + (−x) → +0.
- Writes to any register while busy: `bus_ack_o` is held 0 until the FSM returns to IDLE, then the write is accepted.
- Reads of OPA, OPB and STATUS are always accepted, including while busy.

## Timing
- Reset values:
  - `bus_ack_o` = 0, `bus_resp_o` = 0, `bus_rdata_o` = 0.
  - OPA = OPB = RES = 0, STATUS = 0, FSM in IDLE.
- Read: ack in cycle T; `bus_resp_o` and `bus_rdata_o` registered in T+1.
- Add latency: OPB write acked in cycle T. RES is valid and done = 1 at the end of T+5, so a read acked at T+6 returns the new sum. busy is 1 from T+1 through T+5.
- Back-to-back reads are allowed: one outstanding read per cycle, with `bus_resp_o` in consecutive cycles.
- `rst_i` asserted mid-add: everything returns to reset values in the next cycle. No response is issued for a read pending in that cycle.

## Configuration
- Macro: `FP32ADD_RES_STALL_EN`.
- Defined: a RES read arriving while busy is not acked until the cycle after ROUND. The returned value is always the result of the latest OPB write.
- Undefined: a RES read is acked immediately and returns the current RES register, which may be the stale previous result while busy. Software must poll STATUS.done.

## Test plan
- Write OPA=0x3F800000, OPB=0x40200000, wait 10 cycles, read RES → 0x40600000 (3.5). STATUS read → 0x2.
- Sign combinations (OPA, OPB → RES):
  - 0xBF800000 + 0x40200000 → 0x3FC00000.
  - 0x3F800000 + 0xC0200000 → 0xBFC00000.
  - 0xBF800000 + 0xC0200000 → 0xC0600000.
- Cancellation and rounding (OPA + OPB → RES):
  - 0xBECCCCCD + 0x3E99999A → 0xBDCCCCCC.
  - 0x3F800000 + 0xBF800000 → 0x00000000.
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
- Specials (OPA + OPB → RES):
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x00000001 + 0x3F800000 → 0x3F800000.
- Stall:
  - With `FP32ADD_RES_STALL_EN` defined, read RES in the cycle after the OPB write → ack delayed to T+6, data = new sum.
  - With it undefined → immediate ack with the previous sum.
  - Write OPA while busy → ack withheld until IDLE.
- Reset mid-add: assert `rst_i` at T+3 after an OPB write → RES = 0, STATUS = 0. A subsequent add completes normally.
